// File: rtl/pc_unit.sv
// Program counter and next-fetch-address generator for the single-cycle MIPS datapath.
// Optional MIPS branch delay slot is enabled by defining DELAY_SLOT_EN.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_addr,
    output logic [31:0] PC,
    output logic [31:0] link_addr,
    output logic        fault,
    output logic [15:0] redirect_cnt
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] ctl_target;
    logic [31:0] npc;
    logic        ctl_taken;
    logic        count_inc;
    logic        npc_legal;

    // Candidate control-transfer target, always relative to the registered PC.
    always_comb begin
        pc_plus4    = PC + 32'd4;
        br_target   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        jump_target = {pc_plus4[31:28], imm26, 2'b00};
        ctl_taken   = 1'b0;
        ctl_target  = pc_plus4;
        case (pc_sel)
            2'b01: begin
                ctl_taken  = br_taken;
                ctl_target = br_taken ? br_target : pc_plus4;
            end
            2'b10: begin
                ctl_taken  = 1'b1;
                ctl_target = jump_target;
            end
            2'b11: begin
                ctl_taken  = 1'b1;
                ctl_target = jr_addr;
            end
            default: begin
                ctl_taken  = 1'b0;
                ctl_target = pc_plus4;
            end
        endcase
    end

`ifdef DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;

    // The delay-slot instruction always advances sequentially; a parked target wins next.
    always_comb begin
        npc       = pend_valid ? pend_target : pc_plus4;
        count_inc = pend_valid;
    end

    assign link_addr = PC + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else if (!fault && !stall && npc_legal) begin
            if (pend_valid) begin
                pend_valid <= 1'b0;
            end else if (ctl_taken) begin
                pend_valid  <= 1'b1;
                pend_target <= ctl_target;
            end
        end
    end
`else
    always_comb begin
        npc       = ctl_target;
        count_inc = ctl_taken;
    end

    assign link_addr = PC + 32'd4;
`endif

    assign npc_legal = (npc[1:0] == 2'b00) && (npc >= RESET_PC) && (npc <= LAST_PC);

    // An illegal candidate freezes fetch instead of loading, so PC never leaves memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC           <= RESET_PC;
            fault        <= 1'b0;
            redirect_cnt <= 16'd0;
        end else if (!fault && !stall) begin
            if (!npc_legal) begin
                fault <= 1'b1;
            end else begin
                PC <= npc;
                if (count_inc && redirect_cnt != 16'hFFFF)
                    redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literals. Honours DELAY_SLOT_EN.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 1024;
`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFS = 32'd8;
`else
    localparam logic [31:0] LINK_OFS = 32'd4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_addr;
    logic [31:0] PC;
    logic [31:0] link_addr;
    logic        fault;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc = 32'd0;
    logic        m_fault = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_tgt = 32'd0;
    bit          m_valid = 1'b0;

    pc_unit #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .jr_addr(jr_addr),
        .PC(PC), .link_addr(link_addr), .fault(fault), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit legalPc(logic [31:0] a);
        longint v = longint'(a);
        return (v % 4 == 0) && (v >= longint'(RESET_PC)) &&
               (v < longint'(RESET_PC) + 4 * IM_WORDS);
    endfunction

    function automatic bit takenOf(logic [1:0] sel, logic bt);
        return (sel == 2'd2) || (sel == 2'd3) || (sel == 2'd1 && bt);
    endfunction

    function automatic logic [31:0] targetOf(logic [31:0] pc, logic [1:0] sel, logic bt,
                                             logic [15:0] i16, logic [25:0] i26,
                                             logic [31:0] jra);
        int off = int'($signed(i16));
        case (sel)
            2'd1:    return bt ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
            2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | (32'(i26) * 32'd4);
            2'd3:    return jra;
            default: return pc + 32'd4;
        endcase
    endfunction

    // Reference model: advanced on each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_pc <= RESET_PC; m_fault <= 1'b0; m_cnt <= 16'd0;
            m_pend <= 1'b0; m_pend_tgt <= 32'd0; m_valid <= 1'b1;
        end else if (m_valid && !m_fault && !stall) begin
`ifdef DELAY_SLOT_EN
            if (m_pend) begin
                if (!legalPc(m_pend_tgt)) m_fault <= 1'b1;
                else begin
                    m_pc <= m_pend_tgt;
                    m_pend <= 1'b0;
                    if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                end
            end else if (!legalPc(m_pc + 32'd4)) begin
                m_fault <= 1'b1;
            end else begin
                m_pc <= m_pc + 32'd4;
                if (takenOf(pc_sel, br_taken)) begin
                    m_pend <= 1'b1;
                    m_pend_tgt <= targetOf(m_pc, pc_sel, br_taken, imm16, imm26, jr_addr);
                end
            end
`else
            if (!legalPc(targetOf(m_pc, pc_sel, br_taken, imm16, imm26, jr_addr))) begin
                m_fault <= 1'b1;
            end else begin
                m_pc <= targetOf(m_pc, pc_sel, br_taken, imm16, imm26, jr_addr);
                if (takenOf(pc_sel, br_taken) && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end
`endif
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_pc", PC, m_pc);
            checkOutput("model_fault", {31'd0, fault}, {31'd0, m_fault});
            checkOutput("model_cnt", {16'd0, redirect_cnt}, {16'd0, m_cnt});
            checkOutput("model_link", link_addr, m_pc + LINK_OFS);
        end
    end

    task automatic applyStimulus(logic rst, logic st, logic [1:0] sel, logic bt,
                                 logic [15:0] i16, logic [25:0] i26, logic [31:0] jra);
        reset = rst; stall = st; pc_sel = sel; br_taken = bt;
        imm16 = i16; imm26 = i26; jr_addr = jra;
        @(posedge clk);
        #1;
    endtask

    task automatic seqStep();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic resetStep();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    // With the delay slot, the slot cycle drives a bogus jump that must be ignored.
    task automatic redirectStep(logic [1:0] sel, logic bt, logic [15:0] i16, logic [25:0] i26,
                                logic [31:0] jra, logic [31:0] slot_pc);
        applyStimulus(1'b0, 1'b0, sel, bt, i16, i26, jra);
`ifdef DELAY_SLOT_EN
        checkOutput("slot_pc", PC, slot_pc);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b1, 16'h7FFF, 26'h3FF_FFFF, 32'h0000_3FFC);
`endif
    endtask

    initial begin
        resetStep();
        resetStep();
        checkOutput("rst_pc", PC, 32'h3000);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
`ifdef DELAY_SLOT_EN
        checkOutput("rst_link", link_addr, 32'h3008);
`else
        checkOutput("rst_link", link_addr, 32'h3004);
`endif
        for (int i = 1; i <= 4; i++) begin
            seqStep();
            checkOutput("seq_pc", PC, 32'h3000 + 32'(4 * i));
        end
        redirectStep(2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h3014);
        checkOutput("br_back_pc", PC, 32'h3004);
        checkOutput("br_back_cnt", {16'd0, redirect_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) seqStep();
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        checkOutput("br_nt_pc", PC, 32'h3014);
        checkOutput("br_nt_cnt", {16'd0, redirect_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) seqStep();
`ifdef DELAY_SLOT_EN
        checkOutput("j_link", link_addr, 32'h3028);
`else
        checkOutput("j_link", link_addr, 32'h3024);
`endif
        redirectStep(2'b10, 1'b0, 16'h0, 26'h000_0C40, 32'h0, 32'h3024);
        checkOutput("j_pc", PC, 32'h3100);
        checkOutput("j_cnt", {16'd0, redirect_cnt}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 16'h0, 26'h000_0C48, 32'h0);
            checkOutput("stall_pc", PC, 32'h3100);
            checkOutput("stall_cnt", {16'd0, redirect_cnt}, 32'd2);
        end
        redirectStep(2'b10, 1'b0, 16'h0, 26'h000_0C48, 32'h0, 32'h3104);
        checkOutput("unstall_pc", PC, 32'h3120);
        checkOutput("unstall_cnt", {16'd0, redirect_cnt}, 32'd3);
        redirectStep(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3002, 32'h3124);
        checkOutput("misalign_fault", {31'd0, fault}, 32'd1);
`ifdef DELAY_SLOT_EN
        checkOutput("misalign_pc", PC, 32'h3124);
`else
        checkOutput("misalign_pc", PC, 32'h3120);
`endif
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 26'h000_0C40, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3000);
        seqStep();
        checkOutput("sticky_fault", {31'd0, fault}, 32'd1);
        checkOutput("sticky_cnt", {16'd0, redirect_cnt}, 32'd3);
        resetStep();
        checkOutput("clr_pc", PC, 32'h3000);
        checkOutput("clr_fault", {31'd0, fault}, 32'd0);
        redirectStep(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3FFC, 32'h3004);
        checkOutput("top_pc", PC, 32'h3FFC);
        seqStep();
        checkOutput("over_fault", {31'd0, fault}, 32'd1);
        checkOutput("over_pc", PC, 32'h3FFC);
        resetStep();
        redirectStep(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_2FFC, 32'h3004);
        checkOutput("under_fault", {31'd0, fault}, 32'd1);
        resetStep();
        redirectStep(2'b01, 1'b1, 16'h03FF, 26'h0, 32'h0, 32'h3004);
        checkOutput("br_over_fault", {31'd0, fault}, 32'd1);
`ifdef DELAY_SLOT_EN
        checkOutput("br_over_pc", PC, 32'h3004);
`else
        checkOutput("br_over_pc", PC, 32'h3000);
`endif
        resetStep();
        redirectStep(2'b01, 1'b1, 16'h000F, 26'h0, 32'h0, 32'h3004);
        checkOutput("br_fwd_pc", PC, 32'h3040);
        checkOutput("br_fwd_cnt", {16'd0, redirect_cnt}, 32'd1);
        resetStep();
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 16'h000F, 26'h0, 32'h0);
        resetStep();
        seqStep();
        checkOutput("rst_pend_pc", PC, 32'h3004);
        checkOutput("rst_pend_cnt", {16'd0, redirect_cnt}, 32'd0);
        resetStep();
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 16'h000F, 26'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        seqStep();
`ifdef DELAY_SLOT_EN
        checkOutput("stall_pend_pc", PC, 32'h3040);
`else
        checkOutput("stall_pend_pc", PC, 32'h3044);
`endif
        checkOutput("stall_pend_cnt", {16'd0, redirect_cnt}, 32'd1);
`ifndef DELAY_SLOT_EN
        resetStep();
        for (int i = 0; i < 65537; i++)
            applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3000);
        checkOutput("sat_cnt", {16'd0, redirect_cnt}, 32'h0000_FFFF);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
